alu_result_monitor: RTL

- Downstream consumer of the ALU stage: samples the 32-bit result Q and its Low/Media/High band flags on each valid cycle.
- Maintains saturating per-band occurrence counters and a saturating signed running sum.
- Runs an alarm state machine that latches when ALARM_RUN consecutive results fall in the same extreme band (High or Low).
- Alarm and statistics are read by the bench scoreboard and by later control logic.

---
 rtl/alu_mon_pkg.sv | 25 ++
 rtl/sat_counter.sv | 29 ++
 rtl/alu_result_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_mon_pkg.sv
// alu_mon_pkg: shared types and constants for the ALU result monitor.
//   mon_state_t  : alarm FSM states
//   alarm_kind_t : encoding of the Alarm_kind output
//   BAND_*_TH    : band thresholds shared with the ALU checker
//   MINMAX_EN    : 1 when built with ALU_MON_MINMAX_EN
package alu_mon_pkg;

   typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO, ALARM} mon_state_t;

   typedef enum logic [1:0] {
      ALM_NONE = 2'd0,
      ALM_HIGH = 2'd1,
      ALM_LOW  = 2'd2
   } alarm_kind_t;

   localparam int BAND_HI_TH = 1_000_000_000;
   localparam int BAND_LO_TH = 10_000_000;

`ifdef ALU_MON_MINMAX_EN
   localparam bit MINMAX_EN = 1'b1;
`else
   localparam bit MINMAX_EN = 1'b0;
`endif

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_inc   : add one this cycle (ignored once saturated)
//   i_clr   : synchronous clear, wins over i_inc
//   o_cnt   : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && !(&r_cnt))
         r_cnt <= r_cnt + 1'b1;

   assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: band statistics, saturating signed sum and run alarm for ALU results.
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   Q_valid, Q          : sample strobe and signed 32-bit result
//   Low, Media, High    : band flags of the sample
//   Clear               : synchronous clear of all state (beats a same-cycle sample)
//   Low/Media/High_cnt  : saturating per-band occurrence counters
//   Sum                 : signed saturating sum of valid Q
//   Alarm, Alarm_kind   : latched alarm, 1 = high run, 2 = low run
//   Min_q, Max_q        : signed extremes of Q, present only with ALU_MON_MINMAX_EN
module alu_result_monitor
   import alu_mon_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int SUM_W     = 48,
   parameter int ALARM_RUN = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Q_valid,
   input  logic [31:0]      Q,
   input  logic             Low,
   input  logic             Media,
   input  logic             High,
   input  logic             Clear,
   output logic [CNT_W-1:0] Low_cnt,
   output logic [CNT_W-1:0] Media_cnt,
   output logic [CNT_W-1:0] High_cnt,
   output logic [SUM_W-1:0] Sum,
   output logic             Alarm,
   output logic [1:0]       Alarm_kind
`ifdef ALU_MON_MINMAX_EN
   ,
   output logic [31:0]      Min_q,
   output logic [31:0]      Max_q
`endif
);

   localparam int RUN_W = $clog2(ALARM_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(ALARM_RUN);
   localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
   localparam logic [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

   sat_counter #(.W(CNT_W)) u_low_cnt (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_inc(Q_valid & Low), .i_clr(Clear), .o_cnt(Low_cnt)
   );
   sat_counter #(.W(CNT_W)) u_media_cnt (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_inc(Q_valid & Media), .i_clr(Clear), .o_cnt(Media_cnt)
   );
   sat_counter #(.W(CNT_W)) u_high_cnt (
      .i_clk(Clk), .i_rst_n(Reset_n), .i_inc(Q_valid & High), .i_clr(Clear), .o_cnt(High_cnt)
   );

   // One guard bit above the accumulator: disagreement between the top two
   // bits of the sum means signed overflow, and the guard bit gives its sign.
   logic [SUM_W-1:0] r_sum;
   logic [SUM_W:0]   w_sum_add;
   logic [SUM_W-1:0] w_sum_nxt;

   assign w_sum_add = {r_sum[SUM_W-1], r_sum} + {{(SUM_W-31){Q[31]}}, Q};
   assign w_sum_nxt = (w_sum_add[SUM_W] ^ w_sum_add[SUM_W-1])
                    ? (w_sum_add[SUM_W] ? SUM_MIN : SUM_MAX)
                    : w_sum_add[SUM_W-1:0];

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n)
         r_sum <= '0;
      else if (Clear)
         r_sum <= '0;
      else if (Q_valid)
         r_sum <= w_sum_nxt;

   assign Sum = r_sum;

   mon_state_t  r_state, w_state_nxt;
   logic [RUN_W-1:0] r_run, w_run_nxt;
   alarm_kind_t r_kind, w_kind_nxt;
   logic        r_alarm, w_alarm_nxt;
   logic        w_mid;

   // High together with Low is contradictory and breaks any run, like Media.
   assign w_mid = Media | (High & Low);

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         r_state <= IDLE;
         r_run   <= '0;
         r_alarm <= 1'b0;
         r_kind  <= ALM_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_alarm <= w_alarm_nxt;
         r_kind  <= w_kind_nxt;
      end

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      if (Q_valid && r_state != ALARM) begin
         if (w_mid) begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
         end else if (High) begin
            w_run_nxt   = (r_state == RUN_HI) ? r_run + 1'b1 : RUN_W'(1);
            w_state_nxt = (w_run_nxt == RUN_LIM) ? ALARM : RUN_HI;
         end else if (Low) begin
            w_run_nxt   = (r_state == RUN_LO) ? r_run + 1'b1 : RUN_W'(1);
            w_state_nxt = (w_run_nxt == RUN_LIM) ? ALARM : RUN_LO;
         end
      end
      if (Clear) begin
         w_state_nxt = IDLE;
         w_run_nxt   = '0;
      end
   end

   // Entry into ALARM can only come from a lone High or a lone Low sample.
   always_comb begin
      w_alarm_nxt = (w_state_nxt == ALARM);
      w_kind_nxt  = (w_state_nxt != ALARM) ? ALM_NONE
                  : (r_state == ALARM)     ? r_kind
                  : High                   ? ALM_HIGH : ALM_LOW;
   end

   assign Alarm      = r_alarm;
   assign Alarm_kind = r_kind;

`ifdef ALU_MON_MINMAX_EN
   logic        r_seen;
   logic [31:0] r_min, r_max;

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         r_seen <= 1'b0;
         r_min  <= 32'h7FFF_FFFF;
         r_max  <= 32'h8000_0000;
      end else if (Clear) begin
         r_seen <= 1'b0;
         r_min  <= 32'h7FFF_FFFF;
         r_max  <= 32'h8000_0000;
      end else if (Q_valid) begin
         r_seen <= 1'b1;
         if (!r_seen || $signed(Q) < $signed(r_min))
            r_min <= Q;
         if (!r_seen || $signed(Q) > $signed(r_max))
            r_max <= Q;
      end

   assign Min_q = r_min;
   assign Max_q = r_max;
`else
`endif

endmodule
